// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with enable, clear, load, terminal count,
// wrap pulse and sticky overflow. Define COUNTER_SATURATE_EN to saturate instead of wrapping.
module mod_updown_counter #(
    parameter int WIDTH  = 3,
    parameter int MODULO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // One extra bit so MODULO == 2**WIDTH still compares correctly against din.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bot, tc_w;

    assign at_top = (count_q == MAX_VAL);
    assign at_bot = (count_q == '0);
    assign tc_w   = en & ((up & at_top) | (~up & at_bot));

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = ({1'b0, din} < MOD_EXT) ? din : MAX_VAL;
        end else if (en) begin
            if (tc_w) begin
                // Terminal step: flag it whether we wrap or hold at the limit.
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
`ifdef COUNTER_SATURATE_EN
                count_d = count_q;
`else
                count_d = up ? '0 : MAX_VAL;
`endif
            end else begin
                count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_w;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule
